// File: rtl/spi_pkg.sv
// Shared SPI frame layout and controller FSM states.
// Used by both the controller and the peripheral side.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int WR_BIT  = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                      = '0;
        f[WR_BIT]              = wr;
        f[WR_BIT-1 -: ADDR_W]  = addr;
        f[DATA_W-1:0]          = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SCLK.
// The counter is held at zero whenever shifting is not in progress.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master sending one 16-bit {wr, addr, wdata} frame per start.
// The receive register keeps the last 8 bits sampled on miso.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
    localparam logic [4:0] BIT_LAST   = 5'(FRAME_W - 1);

    spi_state_t          state;
    logic [7:0]          cnt;
    logic [4:0]          bit_cnt;
    logic [FRAME_W-1:0]  tx;
    logic [DATA_W-1:0]   rx;
    logic                tick;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == SHIFT),
        .tick (tick)
    );

    // mosi is the top flop of the transmit register
    assign mosi = tx[FRAME_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx      <= pack_frame(wr, addr, wdata);
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (!sclk) begin
                            rx <= {rx[DATA_W-2:0], miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            tx      <= {tx[FRAME_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        rdata <= rx;
                        tx    <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: register-file peripheral model, frame scoreboard,
// reset abort, back-to-back starts and a fast-divider instance.
module tb_spi_controller;

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, start, wr, miso;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       busy, done, sclk, cs_n, mosi;

    logic       start2;
    logic [7:0] rdata2;
    logic       busy2, done2, sclk2, cs2, mosi2;

    int   vecs = 0;
    int   miss = 0;
    exp_t sbq[$];
    vec_t tv[11];

    always #5 clk = ~clk;

    spi_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .rdata(rdata),
        .sclk (sclk),
        .cs_n (cs_n),
        .mosi (mosi),
        .miso (miso)
    );

    spi_controller #(
        .CLK_DIV (2),
        .CS_SETUP(1)
    ) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start2),
        .wr   (1'b1),
        .addr (7'h55),
        .wdata(8'hFF),
        .busy (busy2),
        .done (done2),
        .rdata(rdata2),
        .sclk (sclk2),
        .cs_n (cs2),
        .mosi (mosi2),
        .miso (1'b1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peripheral: 128 x 8 register file, mode 0, reads answer in bits 7:0
    logic        p_init;
    logic        ps_q, pc_q;
    logic [15:0] prx;
    logic [7:0]  ptx;
    logic [7:0]  pregs[128];
    int          pcnt;

    always @(posedge clk) begin
        ps_q <= sclk;
        pc_q <= cs_n;
        if (p_init) begin
            for (int i = 0; i < 128; i++) pregs[i] <= 8'h00;
            pregs[2] <= 8'h3C;
            miso     <= 1'b0;
            ptx      <= 8'h00;
            prx      <= 16'h0;
            pcnt     <= 0;
        end else begin
            if (!cs_n && pc_q)
                pcnt <= 0;
            else if (cs_n && !pc_q && pcnt == 16 && prx[15])
                pregs[prx[14:8]] <= prx[7:0];
            if (!cs_n && sclk && !ps_q) begin
                prx  <= {prx[14:0], mosi};
                pcnt <= pcnt + 1;
            end
            if (!cs_n && !sclk && ps_q) begin
                if (pcnt == 8) begin
                    miso <= pregs[prx[6:0]][7];
                    ptx  <= {pregs[prx[6:0]][6:0], 1'b0};
                end else begin
                    miso <= ptx[7];
                    ptx  <= {ptx[6:0], 1'b0};
                end
            end
        end
    end

    // Monitor: captures mosi on sclk rises, pops the scoreboard on done
    initial begin : mon
        logic        ps, pcs, seen;
        int          cs_low, hi_cnt, nbits;
        logic [15:0] cap;
        exp_t        e;
        ps = 0; pcs = 1; seen = 0;
        cs_low = 0; hi_cnt = 0; nbits = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ps = 0; pcs = 1; seen = 0;
                cs_low = 0; hi_cnt = 0; nbits = 0; cap = '0;
            end else begin
                if (pcs && !cs_n) begin
                    if (seen) check("cs_gap_ge4", 32'(hi_cnt >= 4), 1);
                    cs_low = 0; nbits = 0; cap = '0;
                end
                if (!pcs && cs_n) hi_cnt = 0;
                if (cs_n) hi_cnt++;
                else cs_low++;
                if (!ps && sclk) begin
                    cap = {cap[14:0], mosi};
                    nbits++;
                end
                if (done) begin
                    seen = 1;
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 0, 1);
                    end else begin
                        e = sbq.pop_front();
                        check("mosi_frame", 32'(cap), 32'(e.frame));
                        check("rdata", 32'(rdata), 32'(e.rdata));
                        check("cs_low_cycles", 32'(cs_low), 132);
                        check("sclk_rises", 32'(nbits), 16);
                    end
                end
                ps  = sclk;
                pcs = cs_n;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    // Accept a frame, then scramble inputs and re-pulse start while busy
    task automatic send(input vec_t v, input bit track);
        wait_idle();
        wr = v.wr; addr = v.addr; wdata = v.wdata; start = 1'b1;
        if (track)
            sbq.push_back('{frame: {v.wr, v.addr, v.wdata}, rdata: v.exp_rdata});
        @(negedge clk);
        check("busy_on_accept", 32'(busy), 1);
        wr = ~v.wr; addr = ~v.addr; wdata = ~v.wdata;
        @(negedge clk);
        start = 1'b0;
        if (track) wait_done();
    endtask

    initial begin
        int   t, rises, low2, pbad, sbad, last_rise, cyc;
        logic ps2, mprev;
        logic [15:0] cap2;
        vec_t abort_v;
        logic [7:0] lb [4];

        tv[0]  = '{1'b1, 7'h03, 8'hA5, 8'h00};
        tv[1]  = '{1'b0, 7'h02, 8'h00, 8'h3C};
        tv[2]  = '{1'b1, 7'h01, 8'h11, 8'h00};
        tv[3]  = '{1'b1, 7'h02, 8'h22, 8'h3C};
        tv[4]  = '{1'b1, 7'h04, 8'h44, 8'h00};
        tv[5]  = '{1'b0, 7'h03, 8'h00, 8'hA5};
        tv[6]  = '{1'b0, 7'h04, 8'h00, 8'h44};
        tv[7]  = '{1'b0, 7'h01, 8'h00, 8'h11};
        tv[8]  = '{1'b1, 7'h7F, 8'h5A, 8'h00};
        tv[9]  = '{1'b0, 7'h7F, 8'h00, 8'h5A};
        tv[10] = '{1'b0, 7'h02, 8'h00, 8'h22};
        abort_v = '{1'b1, 7'h01, 8'hEE, 8'h00};
        lb = '{8'h11, 8'h22, 8'hA5, 8'h44};

        rst_n = 1'b0; p_init = 1'b1; start = 1'b0; start2 = 1'b0;
        wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", 32'(rdata), 0);
        rst_n = 1'b1; p_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) send(tv[i], 1'b1);

        // start held high across two frames
        wait_idle();
        sbq.push_back('{frame: {tv[5].wr, tv[5].addr, tv[5].wdata}, rdata: tv[5].exp_rdata});
        sbq.push_back('{frame: {tv[6].wr, tv[6].addr, tv[6].wdata}, rdata: tv[6].exp_rdata});
        wr = tv[5].wr; addr = tv[5].addr; wdata = tv[5].wdata; start = 1'b1;
        @(negedge clk);
        wr = tv[6].wr; addr = tv[6].addr; wdata = tv[6].wdata;
        t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("held_busy_drop", 32'(busy), 0);
        @(negedge clk);
        check("held_reaccept", 32'(busy), 1);
        start = 1'b0;
        wait_done();

        // reset at the 8th sclk rise of a write to addr 1
        send(abort_v, 1'b0);
        rises = 0; ps2 = sclk; t = 0;
        while (rises < 8 && t < 1000) begin
            if (sclk && !ps2) rises++;
            ps2 = sclk;
            if (rises < 8) @(negedge clk);
            t++;
        end
        check("abort_reach_8_rises", 32'(rises), 8);
        rst_n = 1'b0;
        #1;
        check("abort_sclk", 32'(sclk), 0);
        check("abort_cs_n", 32'(cs_n), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_mosi", 32'(mosi), 0);
        check("abort_rdata", 32'(rdata), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_auto_start", 32'(cs_n), 1);

        for (int i = 7; i < 11; i++) send(tv[i], 1'b1);

        t = 0;
        while (sbq.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("queue_drained", 32'(sbq.size()), 0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check("loopback_reg", 32'(pregs[i+1]), 32'(lb[i]));

        // fast instance: CLK_DIV=2, CS_SETUP=1
        start2 = 1'b1;
        ps2 = 0; rises = 0; low2 = 0; pbad = 0; sbad = 0;
        last_rise = 0; cyc = 0; cap2 = '0; mprev = 0; t = 0;
        while (t < 300) begin
            @(negedge clk);
            start2 = 1'b0;
            cyc++;
            if (!cs2) low2++;
            if (sclk2 && !ps2) begin
                if (rises > 0 && cyc - last_rise != 4) pbad++;
                if (mosi2 !== mprev) sbad++;
                last_rise = cyc;
                cap2 = {cap2[14:0], mosi2};
                rises++;
            end
            ps2 = sclk2;
            mprev = mosi2;
            if (done2) break;
            t++;
        end
        check("u2_done", 32'(done2), 1);
        check("u2_cs_low_cycles", 32'(low2), 66);
        check("u2_frame", 32'(cap2), 32'h0000D5FF);
        check("u2_rises", 32'(rises), 16);
        check("u2_period_bad", 32'(pbad), 0);
        check("u2_mosi_unstable", 32'(sbad), 0);
        check("u2_rdata", 32'(rdata2), 32'h000000FF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
